// File: rtl/tm_snn_pkg.sv
// Shared definitions for the time-multiplexed SNN slice: neuron-array defaults,
// decoder state encoding and the spike-count type.
package tm_snn_pkg;

    localparam int unsigned NEURONS_DEF       = 8;
    localparam int unsigned SLOT_W_DEF        = $clog2(NEURONS_DEF);
    localparam int unsigned CNT_W_DEF         = 4;
    localparam int unsigned WINDOW_FRAMES_DEF = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } dec_state_e;

    typedef logic [CNT_W_DEF-1:0] count_t;

endpackage

// File: rtl/tm_rate_bank.sv
// Live/shadow spike-count arrays for the spike decoder.
// TM_DEC_SATURATE_EN: live counters saturate instead of wrapping.
module tm_rate_bank
    import tm_snn_pkg::*;
#(
    parameter int unsigned NEURONS = NEURONS_DEF,
    parameter int unsigned SLOT_W  = SLOT_W_DEF,
    parameter int unsigned CNT_W   = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inc_en,
    input  logic [SLOT_W-1:0] inc_idx,
    input  logic              clear,
    input  logic              snap,
    input  logic [SLOT_W-1:0] rd_idx,
    output logic [CNT_W-1:0]  rd_count_c
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] live_q   [NEURONS];
    logic [CNT_W-1:0] shadow_q [NEURONS];
    logic [CNT_W-1:0] live_inc [NEURONS];

    // Live value including this cycle's increment; this is what a snapshot captures.
    always_comb begin
        for (int i = 0; i < int'(NEURONS); i++) begin
            live_inc[i] = live_q[i];
            if (inc_en && (inc_idx == SLOT_W'(i))) begin
`ifdef TM_DEC_SATURATE_EN
                if (live_q[i] != CNT_MAX) begin
                    live_inc[i] = live_q[i] + CNT_W'(1);
                end
`else
                live_inc[i] = live_q[i] + CNT_W'(1);
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NEURONS); i++) begin
                live_q[i]   <= '0;
                shadow_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(NEURONS); i++) begin
                live_q[i] <= clear ? '0 : live_inc[i];
                if (snap) begin
                    shadow_q[i] <= live_inc[i];
                end
            end
        end
    end

    // Read port returns the value the shadow holds after this edge.
    always_comb begin
        rd_count_c = snap ? live_inc[rd_idx] : shadow_q[rd_idx];
    end

endmodule

// File: rtl/tm_spike_decoder.sv
// Slot-tagged spike stream to per-neuron windowed spike counts, drained over valid/ready.
// TM_DEC_SATURATE_EN selects saturating (defined) or wrapping (undefined) counters.
module tm_spike_decoder
    import tm_snn_pkg::*;
#(
    parameter int unsigned NEURONS       = NEURONS_DEF,
    parameter int unsigned SLOT_W        = SLOT_W_DEF,
    parameter int unsigned CNT_W         = CNT_W_DEF,
    parameter int unsigned WINDOW_FRAMES = WINDOW_FRAMES_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [SLOT_W-1:0] in_slot,
    input  logic              in_spike,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [SLOT_W-1:0] out_id,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_last,
    output logic              overrun
);

    localparam int unsigned       FRAME_W    = (WINDOW_FRAMES > 1) ? $clog2(WINDOW_FRAMES) : 1;
    localparam logic [SLOT_W-1:0]  LAST_SLOT  = SLOT_W'(NEURONS - 1);
    localparam logic [FRAME_W-1:0] LAST_FRAME = FRAME_W'(WINDOW_FRAMES - 1);

    dec_state_e         state_q, state_d;
    logic [SLOT_W-1:0]  rd_q, rd_d;
    logic [FRAME_W-1:0] frame_q;
    logic               accept, frame_end, win_end;
    logic               hs, last_hs, snap, overrun_d;
    logic [CNT_W-1:0]   rd_count_c;

    always_comb begin
        accept    = in_valid && (32'(in_slot) < NEURONS);
        frame_end = accept && (in_slot == LAST_SLOT);
        win_end   = frame_end && (frame_q == LAST_FRAME);
        hs        = (state_q == DRAIN) && out_ready;
        last_hs   = hs && (rd_q == LAST_SLOT);
    end

    tm_rate_bank #(
        .NEURONS (NEURONS),
        .SLOT_W  (SLOT_W),
        .CNT_W   (CNT_W)
    ) u_bank (
        .clk        (clk),
        .rst_n      (rst_n),
        .inc_en     (accept && in_spike),
        .inc_idx    (in_slot),
        .clear      (win_end),
        .snap       (snap),
        .rd_idx     (rd_d),
        .rd_count_c (rd_count_c)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_q <= '0;
        end else if (frame_end) begin
            frame_q <= (frame_q == LAST_FRAME) ? '0 : frame_q + FRAME_W'(1);
        end
    end

    // Next-state: a window end is only snapshotted when no drain is still pending.
    always_comb begin
        state_d   = state_q;
        rd_d      = rd_q;
        snap      = 1'b0;
        overrun_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (win_end) begin
                    state_d = DRAIN;
                    rd_d    = '0;
                    snap    = 1'b1;
                end
            end
            DRAIN: begin
                if (hs) begin
                    if (last_hs) begin
                        state_d = IDLE;
                        rd_d    = '0;
                    end else begin
                        rd_d = rd_q + SLOT_W'(1);
                    end
                end
                if (win_end) begin
                    if (last_hs) begin
                        state_d = DRAIN;
                        rd_d    = '0;
                        snap    = 1'b1;
                    end else begin
                        overrun_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rd_q      <= '0;
            out_valid <= 1'b0;
            out_id    <= '0;
            out_count <= '0;
            out_last  <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_q      <= rd_d;
            out_valid <= (state_d == DRAIN);
            out_id    <= (state_d == DRAIN) ? rd_d : '0;
            out_count <= (state_d == DRAIN) ? rd_count_c : '0;
            out_last  <= (state_d == DRAIN) && (rd_d == LAST_SLOT);
            overrun   <= overrun_d;
        end
    end

endmodule

// File: tb/tb_tm_spike_decoder.sv
// Bench for tm_spike_decoder: an 8-neuron and a 6-neuron instance share one stimulus
// stream and are checked every cycle against a spec-level model plus literal expectations.
module tb_tm_spike_decoder;
    import tm_snn_pkg::*;

    localparam int WF = 16;
`ifdef TM_DEC_SATURATE_EN
    localparam int FULL16 = 15;
`else
    localparam int FULL16 = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n, in_valid, in_spike, out_ready;
    logic [2:0] in_slot;
    logic       v8, l8, o8, v6, l6, o6;
    logic [2:0] id8, id6;
    logic [3:0] c8, c6;

    int total = 0;
    int bad   = 0;
    bit checking = 0;

    always #5 clk = ~clk;

    tm_spike_decoder #(.NEURONS(8), .SLOT_W(3), .CNT_W(4), .WINDOW_FRAMES(16)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_slot(in_slot), .in_spike(in_spike),
        .out_valid(v8), .out_ready(out_ready), .out_id(id8), .out_count(c8),
        .out_last(l8), .overrun(o8)
    );

    tm_spike_decoder #(.NEURONS(6), .SLOT_W(3), .CNT_W(4), .WINDOW_FRAMES(16)) dut6 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_slot(in_slot), .in_spike(in_spike),
        .out_valid(v6), .out_ready(out_ready), .out_id(id6), .out_count(c6),
        .out_last(l6), .overrun(o6)
    );

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Spec-level model: counters as ints, a pending-drain flag and a read pointer.
    int m_live   [2][8];
    int m_shadow [2][8];
    int m_frame  [2];
    int m_rd     [2];
    bit m_busy   [2];
    bit m_ovr    [2];

    task automatic model_step(input int k);
        int n, s;
        bit acc, hs, last_hs, wend;
        n = (k == 0) ? 8 : 6;
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                m_live[k][i]   = 0;
                m_shadow[k][i] = 0;
            end
            m_frame[k] = 0; m_rd[k] = 0; m_busy[k] = 0; m_ovr[k] = 0;
            return;
        end
        s       = int'(in_slot);
        acc     = in_valid && (s < n);
        hs      = m_busy[k] && out_ready;
        last_hs = hs && (m_rd[k] == n - 1);
        wend    = acc && (s == n - 1) && (m_frame[k] == WF - 1);
        if (acc && in_spike) begin
`ifdef TM_DEC_SATURATE_EN
            if (m_live[k][s] < 15) m_live[k][s] = m_live[k][s] + 1;
`else
            m_live[k][s] = (m_live[k][s] + 1) % 16;
`endif
        end
        if (acc && s == n - 1) m_frame[k] = (m_frame[k] + 1) % WF;
        m_ovr[k] = 0;
        if (hs) begin
            if (last_hs) m_busy[k] = 0;
            else         m_rd[k] = m_rd[k] + 1;
        end
        if (wend) begin
            if (!m_busy[k]) begin
                for (int i = 0; i < 8; i++) m_shadow[k][i] = m_live[k][i];
                m_busy[k] = 1;
                m_rd[k]   = 0;
            end else begin
                m_ovr[k] = 1;
            end
            for (int i = 0; i < 8; i++) m_live[k][i] = 0;
        end
    endtask

    always @(posedge clk) begin
        model_step(0);
        model_step(1);
    end

    // Handshake capture used by the literal checks.
    int cap_cnt  [2][8];
    int cap_n    [2];
    int cap_last [2];
    int ovr_n    [2];

    task automatic clear_cap();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 8; i++) cap_cnt[k][i] = 0;
            cap_n[k] = 0; cap_last[k] = 0; ovr_n[k] = 0;
        end
    endtask

    function automatic int sum_except(input int k, input int idx);
        int s = 0;
        for (int i = 0; i < 8; i++) if (i != idx) s += cap_cnt[k][i];
        return s;
    endfunction

    task automatic cmp_dut(input int k, input string p, input logic v, input logic [2:0] id,
                           input logic [3:0] c, input logic l, input logic o);
        int n, eid, ecnt;
        n    = (k == 0) ? 8 : 6;
        eid  = m_busy[k] ? m_rd[k] : 0;
        ecnt = m_busy[k] ? m_shadow[k][m_rd[k]] : 0;
        chk({p, "valid"}, int'(v), int'(m_busy[k]));
        chk({p, "id"}, int'(id), eid);
        chk({p, "count"}, int'(c), ecnt);
        chk({p, "last"}, int'(l), int'(m_busy[k] && m_rd[k] == n - 1));
        chk({p, "overrun"}, int'(o), int'(m_ovr[k]));
        if (rst_n && o) ovr_n[k]++;
        if (rst_n && v && out_ready) begin
            cap_cnt[k][id] = int'(c);
            cap_n[k]++;
            cap_last[k] |= int'(l) << id;
        end
    endtask

    bit         p_v8 = 0, p_r = 0, p_rst = 0;
    logic [2:0] p_id8;
    logic [3:0] p_c8;

    always @(negedge clk) begin
        if (checking) begin
            cmp_dut(0, "d8_", v8, id8, c8, l8, o8);
            cmp_dut(1, "d6_", v6, id6, c6, l6, o6);
            if (p_v8 && !p_r && p_rst) begin
                chk("d8_hold_id", int'(id8), int'(p_id8));
                chk("d8_hold_count", int'(c8), int'(p_c8));
            end
        end
        p_v8 = v8; p_r = out_ready; p_rst = rst_n; p_id8 = id8; p_c8 = c8;
    end

    task automatic cyc(input bit v, input int slot, input bit sp, input bit rdy);
        in_valid  = v;
        in_slot   = 3'(slot);
        in_spike  = sp;
        out_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    bit tog = 0;

    // rmode: 0 ready low, 1 ready high, 2 toggling, 3 words 0..6 early then word 7 at window end.
    task automatic window(input logic [7:0] nmask, input logic [15:0] fmask,
                          input logic [7:0] nall, input int rmode, input bit gaps);
        bit sp, r;
        for (int f = 0; f < WF; f++) begin
            for (int s = 0; s < 8; s++) begin
                sp = (nmask[s] && fmask[f]) || nall[s];
                case (rmode)
                    0: r = 0;
                    1: r = 1;
                    2: begin tog = ~tog; r = tog; end
                    default: r = (f == 0 && s < 7) || (f == WF - 1 && s == 7);
                endcase
                cyc(1, s, sp, r);
                if (gaps && s == 3) begin
                    tog = ~tog;
                    cyc(0, 7, 1, tog);
                end
            end
        end
    endtask

    task automatic idle(input int n, input int rmode);
        for (int i = 0; i < n; i++) begin
            if (rmode == 2) tog = ~tog;
            cyc(0, 0, 0, (rmode == 2) ? tog : (rmode == 1));
        end
    endtask

    initial begin
        clear_cap();
        rst_n = 0;
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        @(negedge clk);
        chk("rst_valid", int'(v8), 0);
        chk("rst_id", int'(id8), 0);
        chk("rst_count", int'(c8), 0);
        chk("rst_last", int'(l8), 0);
        chk("rst_overrun", int'(o8), 0);
        chk("rst_valid6", int'(v6), 0);
        checking = 1;
        rst_n = 1;

        // Neuron 2 every frame, ready high.
        clear_cap();
        window(8'h04, 16'hFFFF, 8'h00, 1, 0);
        @(negedge clk);
        chk("lat_valid", int'(v8), 1);
        chk("lat_id", int'(id8), 0);
        chk("d6_timing_id", int'(id6), 2);
        idle(12, 1);
        chk("t1_words", cap_n[0], 8);
        chk("t1_n2", cap_cnt[0][2], FULL16);
        chk("t1_others", sum_except(0, 2), 0);
        chk("t1_last_mask", cap_last[0], 128);
        chk("t1_overrun", ovr_n[0], 0);
        chk("t1_d6_words", cap_n[1], 6);
        chk("t1_d6_n2", cap_cnt[1][2], FULL16);
        chk("t1_d6_last_mask", cap_last[1], 32);

        // Neuron 5 in 3 frames, ready toggling, invalid gap samples.
        clear_cap();
        window(8'h20, 16'h0421, 8'h00, 2, 1);
        idle(20, 2);
        chk("t2_n5", cap_cnt[0][5], 3);
        chk("t2_words", cap_n[0], 8);
        chk("t2_overrun", ovr_n[0], 0);
        chk("t2_d6_n5", cap_cnt[1][5], 3);
        chk("t2_d6_words", cap_n[1], 6);

        // Ready low for two windows: second snapshot dropped.
        clear_cap();
        window(8'h02, 16'h000F, 8'h40, 0, 0);
        window(8'h00, 16'h0000, 8'h08, 0, 0);
        idle(12, 1);
        chk("t3_overrun", ovr_n[0], 1);
        chk("t3_n1", cap_cnt[0][1], 4);
        chk("t3_n6", cap_cnt[0][6], FULL16);
        chk("t3_n3", cap_cnt[0][3], 0);
        chk("t3_words", cap_n[0], 8);
        chk("t3_d6_overrun", ovr_n[1], 1);
        chk("t3_d6_n1", cap_cnt[1][1], 4);
        chk("t3_d6_others", sum_except(1, 1), 0);

        // Last-word handshake coincides with the next window end.
        clear_cap();
        window(8'h01, 16'h5555, 8'h00, 1, 0);
        window(8'h10, 16'h0003, 8'h00, 3, 0);
        chk("t4_words", cap_n[0], 8);
        chk("t4_n0", cap_cnt[0][0], 8);
        chk("t4_no_overrun", ovr_n[0], 0);
        @(negedge clk);
        chk("t4_valid", int'(v8), 1);
        chk("t4_id", int'(id8), 0);
        chk("t4_overrun_now", int'(o8), 0);
        clear_cap();
        idle(12, 1);
        chk("t4_n4", cap_cnt[0][4], 2);
        chk("t4_words2", cap_n[0], 8);
        chk("t4_overrun2", ovr_n[0], 0);

        // Reset at word 3 of a drain.
        clear_cap();
        window(8'h08, 16'h0001, 8'h80, 1, 0);
        cyc(1, 0, 0, 1);
        cyc(1, 1, 1, 1);
        cyc(1, 2, 0, 1);
        @(negedge clk);
        chk("t5_pre_id", int'(id8), 3);
        rst_n = 0;
        cyc(0, 0, 0, 1);
        @(negedge clk);
        chk("t5_rst_valid", int'(v8), 0);
        chk("t5_rst_id", int'(id8), 0);
        chk("t5_rst_count", int'(c8), 0);
        chk("t5_rst_last", int'(l8), 0);
        chk("t5_rst_valid6", int'(v6), 0);
        rst_n = 1;
        clear_cap();
        window(8'h40, 16'h001F, 8'h00, 1, 0);
        idle(12, 1);
        chk("t5_n6", cap_cnt[0][6], 5);
        chk("t5_n1", cap_cnt[0][1], 0);
        chk("t5_n7", cap_cnt[0][7], 0);
        chk("t5_words", cap_n[0], 8);
        chk("t5_overrun", ovr_n[0], 0);

        checking = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
